// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: FSM encoding and default width.
package div_unit_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

endpackage

// File: rtl/div_unit.sv
// Iterative restoring divider, one quotient bit per clock, signed or unsigned.
// Operands are reduced to magnitudes on acceptance and the signs are restored
// in the DONE state, so the core loop is a plain unsigned restoring divide.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int width = DIV_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [width-1:0] dividend,
    input  logic [width-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] quotient,
    output logic [width-1:0] remainder,
    output logic             div_by_zero
);

    localparam int cnt_w = $clog2(width + 1);

    div_state_t       state;
    logic [width-1:0] acc;      // partial remainder
    logic [width-1:0] quo;      // dividend bits shifting out, quotient bits shifting in
    logic [width-1:0] dvs;      // divisor magnitude
    logic [cnt_w-1:0] cnt;
    logic             neg_q;
    logic             neg_r;
    logic             dbz;

    logic [width-1:0] dividend_mag;
    logic [width-1:0] divisor_mag;
    logic [width:0]   shifted;
    logic [width:0]   trial;
    logic [width-1:0] acc_nx;
    logic [width-1:0] quo_nx;

    // Absolute values of the operands; the most-negative value maps onto its
    // unsigned magnitude, which makes the signed overflow case fall out naturally.
    always_comb begin
        dividend_mag = (is_signed && dividend[width-1]) ? -dividend : dividend;
        divisor_mag  = (is_signed && divisor[width-1])  ? -divisor  : divisor;
    end

    // One restoring step: shift in the next dividend bit, trial-subtract, keep
    // the difference only when it did not borrow.
    always_comb begin
        shifted = {acc, quo[width-1]};
        trial   = shifted - {1'b0, dvs};
        if (!trial[width]) begin
            acc_nx = trial[width-1:0];
            quo_nx = {quo[width-2:0], 1'b1};
        end else begin
            acc_nx = shifted[width-1:0];
            quo_nx = {quo[width-2:0], 1'b0};
        end
    end

    // Control FSM with registered outputs; results only update on the DONE exit.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            cnt         <= '0;
            acc         <= '0;
            quo         <= '0;
            dvs         <= '0;
            neg_q       <= 1'b0;
            neg_r       <= 1'b0;
            dbz         <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (divisor == '0) begin
                            // Zero divisor skips the loop; raw dividend is the remainder.
                            acc   <= dividend;
                            quo   <= '1;
                            neg_q <= 1'b0;
                            neg_r <= 1'b0;
                            dbz   <= 1'b1;
                            state <= ST_DONE;
                        end else begin
                            acc   <= '0;
                            quo   <= dividend_mag;
                            dvs   <= divisor_mag;
                            neg_q <= is_signed & (dividend[width-1] ^ divisor[width-1]);
                            neg_r <= is_signed & dividend[width-1];
                            dbz   <= 1'b0;
                            cnt   <= cnt_w'(width);
                            state <= ST_CALC;
                        end
                    end
                end
                ST_CALC: begin
                    acc <= acc_nx;
                    quo <= quo_nx;
                    cnt <= cnt - cnt_w'(1);
                    if (cnt == cnt_w'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // Truncation toward zero: remainder follows the dividend's sign.
                    quotient    <= neg_q ? -quo : quo;
                    remainder   <= neg_r ? -acc : acc;
                    div_by_zero <= dbz;
                    done        <= 1'b1;
                    busy        <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Scoreboard bench for div_unit: driver pushes expected results computed with
// plain integer arithmetic; a negedge monitor pops and compares on done.
module tb_div_unit;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         is_signed;
    logic [W-1:0] dividend;
    logic [W-1:0] divisor;
    logic         busy;
    logic         done;
    logic [W-1:0] quotient;
    logic [W-1:0] remainder;
    logic         div_by_zero;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    div_unit #(.width(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .is_signed   (is_signed),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Reference: integer division semantics straight from the rules.
    function automatic exp_t model(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, qq, rr;
        e.cyc = 0;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
        end else if (!sg) begin
            e.q   = a / b;
            e.r   = a % b;
            e.dbz = 1'b0;
        end else begin
            sa    = $signed(a);
            sbv   = $signed(b);
            qq    = sa / sbv;
            rr    = sa % sbv;
            e.q   = qq[W-1:0];
            e.r   = rr[W-1:0];
            e.dbz = 1'b0;
        end
        return e;
    endfunction

    // Present a request for one cycle; push an expectation only if it should be accepted.
    task automatic issue(input bit sg, input logic [W-1:0] a, input logic [W-1:0] b, input bit accept);
        exp_t e;
        @(negedge clk);
        is_signed = sg;
        dividend  = a;
        divisor   = b;
        start     = 1'b1;
        @(posedge clk);
        #1;
        start     = 1'b0;
        dividend  = $urandom;
        divisor   = $urandom;
        is_signed = $urandom_range(0, 1);
        if (accept) begin
            e     = model(sg, a, b);
            e.cyc = cyc + ((b == '0) ? 1 : W + 1);
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        @(negedge clk);
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: pending=%0d want 0", sb.size());
            sb.delete();
        end
    endtask

    // Monitor: compares each done pulse against the head of the scoreboard and
    // checks busy stays high while a request is outstanding.
    always @(negedge clk) begin
        if (!rst) begin
            if (done) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got done=1 want 0");
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("quotient", quotient, e.q);
                    chk("remainder", remainder, e.r);
                    chk("div_by_zero", 32'(div_by_zero), 32'(e.dbz));
                    chk("done_cycle", 32'(cyc), 32'(e.cyc));
                end
            end else if (sb.size() != 0) begin
                chk("busy_inflight", 32'(busy), 32'd1);
            end
        end
    end

    initial begin
        bit           sg;
        logic [W-1:0] a, b;
        rst = 1'b1; start = 1'b0; is_signed = 1'b0; dividend = '0; divisor = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_quotient", quotient, '0);
        chk("rst_remainder", remainder, '0);
        chk("rst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;

        // Directed corner cases
        issue(0, 32'd100, 32'd7, 1);                 drain();
        issue(1, -32'sd7, 32'd2, 1);                 drain();
        issue(1, 32'd7, -32'sd2, 1);                 drain();
        issue(0, 32'd5, 32'd0, 1);                   drain();
        issue(1, 32'd5, 32'd0, 1);                   drain();
        issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 1);   drain();
        issue(0, 32'h8000_0000, 32'hFFFF_FFFF, 1);   drain();
        chk("hold_quotient", quotient, 32'h0);
        chk("hold_remainder", remainder, 32'h8000_0000);

        // Start while busy is ignored, then accepted once idle
        issue(0, 32'd100, 32'd7, 1);
        repeat (9) @(posedge clk);
        issue(0, 32'd9, 32'd3, 0);
        drain();
        issue(0, 32'd9, 32'd3, 1);                   drain();

        // Start during the DONE-state cycle is ignored
        issue(0, 32'd1000, 32'd10, 1);
        repeat (32) @(posedge clk);
        issue(0, 32'd77, 32'd0, 0);
        drain();
        repeat (4) @(posedge clk);

        // Reset mid-division abandons the operation
        issue(0, 32'd100, 32'd7, 1);
        repeat (14) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        sb.delete();
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_quotient", quotient, '0);
        chk("midrst_remainder", remainder, '0);
        chk("midrst_dbz", 32'(div_by_zero), 32'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        issue(0, 32'd100, 32'd7, 1);                 drain();

        // Reset has priority over a simultaneous start
        @(negedge clk);
        rst = 1'b1; start = 1'b1; divisor = '0; dividend = 32'd5;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        chk("rst_start_busy", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rst_start_done", 32'(done), 32'd0);

        // Randomized operands
        for (int i = 0; i < 40; i++) begin
            sg = $urandom_range(0, 1);
            a  = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
            case ($urandom_range(0, 3))
                0: b = '0;
                1: b = 32'($urandom_range(1, 15));
                2: b = $urandom;
                default: b = '1;
            endcase
            issue(sg, a, b, 1);
            drain();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 The block SHALL have parameter: width, default 32, operand and result bit width.
REQ-002 The block SHALL have port: clk  input  1  rising-edge clock; the block has exactly one clock.
REQ-003 The block SHALL have port: rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port: start  input  1  request to begin a division; sampled only in IDLE.
REQ-005 The block SHALL have port: is_signed  input  1  1 = two's-complement divide, 0 = unsigned divide.
REQ-006 The block SHALL have port: dividend  input  width  numerator; sampled with start.
REQ-007 The block SHALL have port: divisor  input  width  denominator; sampled with start.
REQ-008 The block SHALL have port: busy  output  1  high from the cycle after start is accepted through the DONE cycle inclusive.
REQ-009 The block SHALL have port: done  output  1  single-cycle pulse; results valid in that cycle.
REQ-010 The block SHALL have port: quotient  output  width  registered quotient.
REQ-011 The block SHALL have port: remainder  output  width  registered remainder.
REQ-012 The block SHALL have port: div_by_zero  output  1  registered flag, valid with done.

Function
REQ-013 The block SHALL implement FSM states IDLE, CALC, DONE.
REQ-014 In IDLE with start=1 and divisor!=0, the block SHALL latch |dividend|, |divisor|, the result signs and is_signed, load iteration count=width, and enter CALC.
REQ-015 In CALC the block SHALL perform one restoring-division step per cycle (shift, trial subtract, set quotient bit) for exactly width cycles, then enter DONE.
REQ-016 In DONE the block SHALL apply sign correction, pulse done=1 for one cycle, and return to IDLE.
REQ-017 Latency SHALL be: start sampled at edge k -> done high in the cycle following edge k+width+1 (33 cycles at width=32).
REQ-018 Signed results SHALL truncate toward zero: quotient negated iff operand signs differ; remainder takes the dividend's sign.
REQ-019 In IDLE with start=1 and divisor==0, the block SHALL go directly to DONE with quotient=all ones, remainder=dividend, div_by_zero=1 (done one cycle after start).
REQ-020 Signed overflow (most-negative / -1) SHALL yield quotient=most-negative value, remainder=0, div_by_zero=0.
REQ-021 start asserted while busy=1 SHALL be ignored; no queuing.
REQ-022 start asserted in the DONE cycle SHALL be ignored; a new request is accepted only in IDLE.
REQ-023 quotient, remainder and div_by_zero SHALL hold their values from done until the next done.
REQ-024 Input changes after the start cycle SHALL NOT affect the result in progress.

Reset
REQ-025 With rst=1 at a clock edge, the block SHALL enter IDLE and clear busy, done, quotient, remainder, div_by_zero and the iteration count to 0.
REQ-026 Reset asserted mid-operation SHALL abandon the division without a done pulse.
REQ-027 With rst=1 and start=1 at the same edge, rst SHALL take priority.

Structure
REQ-028 FSM state encoding and the default width constant SHALL live in the shared processor package; no other typedefs are required.
REQ-029 The block SHALL be a single module with no sub-modules; magnitude conversion and sign correction are inline.

Verification
REQ-030 Unsigned 100/7 -> quotient=14, remainder=2, div_by_zero=0, done exactly 33 cycles after start, busy high throughout.
REQ-031 Signed -7/2 -> quotient=-3 (0xFFFFFFFD), remainder=-1 (0xFFFFFFFF); signed 7/-2 -> quotient=-3, remainder=1.
REQ-032 5/0 (either mode) -> quotient=0xFFFFFFFF, remainder=5, div_by_zero=1, done one cycle after start.
REQ-033 Signed 0x80000000/0xFFFFFFFF -> quotient=0x80000000, remainder=0; unsigned same operands -> quotient=0, remainder=0x80000000.
REQ-034 Start 100/7, re-assert start with 9/3 at cycle 10 -> second request ignored, result 14/2; then 9/3 issued in IDLE -> quotient 3, remainder 0.
REQ-035 rst at cycle 15 of a division -> no done pulse, all outputs 0, and the next start completes normally.
